// File: rtl/alub_operand_unit_if.sv
// ALU B operand bus: register/decoder fields in, operand and prefix status out.
// Latency: none, wires only.
// Backpressure: none; the consumer stalls the unit through advance.
interface alub_operand_unit_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int PFX_DEPTH = DATA_WIDTH / 8 - 1;
    localparam int CW        = $clog2(PFX_DEPTH + 1);

    logic [DATA_WIDTH-1:0] alub_din;
    logic [3:0]            alub_srcx;
    logic [3:0]            arga_x;
    logic [3:0]            argb_x;
    logic                  advance;
    logic                  flush;
    logic [DATA_WIDTH-1:0] alub_data;
    logic                  pfx_valid;
    logic [CW-1:0]         pfx_count;
    logic                  pfx_ovf;

    // Decoder / pipeline side.
    modport master (
        output alub_din, alub_srcx, arga_x, argb_x, advance, flush,
        input  alub_data, pfx_valid, pfx_count, pfx_ovf
    );

    // Operand unit side.
    modport slave (
        input  alub_din, alub_srcx, arga_x, argb_x, advance, flush,
        output alub_data, pfx_valid, pfx_count, pfx_ovf
    );
endinterface

// File: rtl/alub_operand_unit.sv
// ALU B operand select with a PFX byte accumulator for wide immediates.
// Latency: operand is combinational; prefix state updates one edge after a PFX retires.
// Backpressure: advance=0 stalls and holds the prefix; flush drops it.
module alub_operand_unit #(
    parameter int DATA_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alub_operand_unit_if.slave bus
);
    localparam int PFX_DEPTH = DATA_WIDTH / 8 - 1;
    localparam int CW        = $clog2(PFX_DEPTH + 1);
    localparam int PW        = DATA_WIDTH - 8;
    localparam logic [CW-1:0] DEPTH_C = CW'(PFX_DEPTH);

    typedef enum logic [3:0] {
        SRC_REG_B = 4'd0,
        SRC_U8H   = 4'd1,
        SRC_U8    = 4'd2,
        SRC_S8    = 4'd3,
        SRC_U4    = 4'd4,
        SRC_U4_0  = 4'd5,
        SRC_U6    = 4'd6,
        SRC_U6_0  = 4'd7,
        SRC_PFX   = 4'd8
    } srcx_e;

    logic [PW-1:0]         pacc, pacc_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  valid_q;
    logic                  ovf_q, ovf_nxt;
    logic [7:0]            i8;
    logic [5:0]            i6;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] imm_u, imm_s;
    logic                  sgn;
    logic [DATA_WIDTH-1:0] operand;

    assign i8      = {bus.arga_x, bus.argb_x};
    assign i6      = {bus.arga_x[3:2], bus.argb_x};
    // Low PW bits of {pacc, i8}: oldest byte falls off the top, new byte enters at the bottom.
    assign shifted = {pacc, i8};

    // Prefix next state: flush beats push, any other retired instruction consumes the prefix.
    always_comb begin
        pacc_nxt = pacc;
        cnt_nxt  = cnt;
        ovf_nxt  = 1'b0;
        if (bus.flush) begin
            pacc_nxt = '0;
            cnt_nxt  = '0;
        end else if (bus.advance) begin
            if (bus.alub_srcx == SRC_PFX) begin
                pacc_nxt = shifted[PW-1:0];
                if (cnt == DEPTH_C) begin
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                pacc_nxt = '0;
                cnt_nxt  = '0;
            end
        end
    end

    // Prefix registers; reset drops any pending prefix immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pacc    <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pacc    <= pacc_nxt;
            cnt     <= cnt_nxt;
            valid_q <= (cnt_nxt != '0);
            ovf_q   <= ovf_nxt;
        end
    end

    // Build {P, I8}: byte k of pacc sits at operand byte k+1; bytes above the prefix are zero or sign fill.
    always_comb begin
        imm_u      = '0;
        imm_s      = '0;
        imm_u[7:0] = i8;
        imm_s[7:0] = i8;
        sgn        = i8[7];
        for (int k = 0; k < PFX_DEPTH; k++) begin
            if (k + 1 == int'(cnt)) begin
                sgn = pacc[k*8+7];
            end
        end
        for (int k = 0; k < PFX_DEPTH; k++) begin
            if (k < int'(cnt)) begin
                imm_u[k*8+8 +: 8] = pacc[k*8 +: 8];
                imm_s[k*8+8 +: 8] = pacc[k*8 +: 8];
            end else begin
                imm_s[k*8+8 +: 8] = {8{sgn}};
            end
        end
    end

    // Operand mux; depends only on data/fields and registered prefix state.
    always_comb begin
        operand = '0;
        case (bus.alub_srcx)
            SRC_REG_B: operand = bus.alub_din;
            SRC_U8H:   operand = {i8, bus.alub_din[DATA_WIDTH-9:0]};
            SRC_U8:    operand = imm_u;
            SRC_S8:    operand = imm_s;
            SRC_U4:    operand = DATA_WIDTH'(bus.argb_x);
            SRC_U4_0:  operand = DATA_WIDTH'({bus.argb_x, 1'b0});
            SRC_U6:    operand = DATA_WIDTH'(i6);
            SRC_U6_0:  operand = DATA_WIDTH'({i6, 1'b0});
            default:   operand = '0;
        endcase
    end

    assign bus.alub_data = operand;
    assign bus.pfx_valid = valid_q;
    assign bus.pfx_count = cnt;
    assign bus.pfx_ovf   = ovf_q;
endmodule

// File: doc/alub_operand_unit.md
# alub_operand_unit

Parametrised successor to the ALU B operand mux. It selects the ALU B operand from the register file or from immediate fields, at a configurable data width. It adds an immediate-prefix accumulator so that a sequence of PFX instructions can build constants wider than 8 bits. The unit sits between the register file/instruction decoder and ALU input B; the operand path is combinational and the prefix state is registered.

## Interface
- DATA_WIDTH, default 16: operand width; must be a multiple of 8 and ≥16.
- Derived PFX_DEPTH = DATA_WIDTH/8 − 1: maximum number of prefix bytes held.
- Derived CW = clog2(PFX_DEPTH+1): width of PFX_COUNT.

Ports:
- CLK  in  1  system clock; rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ALUB_DIN  in  DATA_WIDTH  register B data.
- ALUB_SRCX  in  4  operand source select.
- ARGA_X  in  4  instruction A field.
- ARGB_X  in  4  instruction B field.
- ADVANCE  in  1  the current instruction executes (retires) this cycle; 0 = stall.
- FLUSH  in  1  discard any pending prefix (taken branch, interrupt).
- ALUB_DATA  out  DATA_WIDTH  operand to ALU B; combinational.
- PFX_VALID  out  1  a prefix is pending; registered.
- PFX_COUNT  out  CW  number of prefix bytes pending; registered.
- PFX_OVF  out  1  one-cycle pulse when a prefix byte was pushed out of a full accumulator.

## Operation
- Let I8 = {ARGA_X, ARGB_X}.
- Let I6 = {ARGA_X[3:2], ARGB_X}.
- Let P = the low 8·PFX_COUNT bits of the accumulator PACC (width DATA_WIDTH−8).
- SRCX encoding and ALUB_DATA:
  - 0 REG_B: ALUB_DIN.
  - 1 U8H: ALUB_DIN with its top 8 bits replaced by I8.
  - 2 U8: {P, I8}, zero-extended.
  - 3 S8: {P, I8}, sign-extended from bit 8·PFX_COUNT+7.
  - 4 U4: ARGB_X, zero-extended.
  - 5 U4_0: ARGB_X<<1, zero-extended.
  - 6 U6: I6, zero-extended.
  - 7 U6_0: I6<<1, zero-extended.
  - 8 PFX: 0.
  - 9–15: reserved; output 0.
- With PFX_COUNT = 0, modes 0–7 behave exactly as the legacy mux, zero- or sign-extended to DATA_WIDTH.
- Modes 0, 1 and 4–7 ignore P.
- Prefix state update, evaluated at each rising CLK edge in priority order:
  1. FLUSH=1: PACC←0, PFX_COUNT←0, regardless of ADVANCE.
  2. ADVANCE=1 and SRCX=PFX: PACC←{PACC[DATA_WIDTH−17:0], I8}.
     - PFX_COUNT increments, saturating at PFX_DEPTH.
     - If PFX_COUNT was already PFX_DEPTH, PFX_OVF=1 for the following cycle; the oldest byte is lost.
  3. ADVANCE=1 and any other SRCX: PACC←0, PFX_COUNT←0. A prefix is valid only for the immediately following instruction.
  4. ADVANCE=0: hold all state (stall). ALUB_DATA keeps reflecting the pending prefix.
- PFX_VALID = (PFX_COUNT ≠ 0), registered alongside PFX_COUNT.
- PFX_OVF is 0 in every cycle not covered by rule 2.
- At DATA_WIDTH=16, PACC is 8 bits wide (DATA_WIDTH−17 = −1) and the shift in rule 2 degenerates to PACC←I8.

## Timing
- RESET low forces, immediately and without waiting for CLK: PACC=0, PFX_COUNT=0, PFX_VALID=0, PFX_OVF=0.
- During reset, ALUB_DATA follows the legacy mux function.
- If reset is asserted mid-sequence, a pending prefix is dropped. The first instruction after release sees no prefix.
- ALUB_DATA has zero-cycle latency from ALUB_DIN, SRCX and the ARG fields.
- ALUB_DATA reflects a prefix pushed at edge N from cycle N onward, i.e. the cycle after the PFX instruction advanced.
- The consumer uses the prefix in the cycle its ADVANCE is high. The prefix clears at that edge.
- No combinational path from ADVANCE or FLUSH to ALUB_DATA.
- Simultaneous FLUSH and ADVANCE on PFX: flush wins; no push and no overflow pulse.

## Test plan
- Reset and legacy modes (DATA_WIDTH=16; DIN=1234h, A=Ah, B=5h):
  - Hold RESET low → PFX_VALID=0, PFX_COUNT=0.
  - REG_B → 1234h; U8H → A534h.
  - A=8h, B=1h: U8 → 0081h; S8 → FF81h; U4 → 0001h; U4_0 → 0002h.
  - A=8h, B=Ah: U6 → 002Ah; U6_0 → 0054h.
- Prefix build: PFX I8=12h with ADVANCE for one edge → PFX_COUNT=1, PFX_VALID=1; then U8 I8=34h → ALUB_DATA=1234h; after the ADVANCE edge → PFX_VALID=0 and U8 reads 0034h.
- Sign extension (DATA_WIDTH=32): PFX 80h then S8 01h → FFFF8001h; same with U8 → 00008001h; PFX 12h, 34h, 56h then U8 78h → 12345678h, PFX_COUNT=3.
- Stall and flush (DATA_WIDTH=16): PFX 12h, then U8 34h with ADVANCE=0 for 3 cycles → 1234h held each cycle, PFX_COUNT=1; FLUSH=1 with ADVANCE=1 → next cycle U8 34h reads 0034h.
- Overflow (DATA_WIDTH=16): PFX 11h then PFX 22h → PFX_OVF=1 for exactly one cycle after the second edge, PFX_COUNT stays 1; U8 33h → 2233h.
- Async reset mid-operation: PFX 12h pushed, RESET driven low between edges → PFX_VALID=0 immediately; after release, U8 34h → 0034h.
